registers_bank_param: RTL and testbench
=======================================

Name: registers_bank_param

Overview:
Parametrised, clocked successor to the core's general-purpose register bank: one synchronous write port and two registered read ports (RS/RT).
- After reset, an internal sequencer clears every register, one per cycle, and raises ready when the bank is usable.
- Optional write-to-read bypass.
- Sits between decode (addresses) and execute/writeback (data) in the MUSA datapath.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH (derived localparam)
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes ignored, reads return 0); 0 = register 0 is ordinary

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
rs  in  ADDR_WIDTH  read address, port 1
rt  in  ADDR_WIDTH  read address, port 2
rd  in  ADDR_WIDTH  write address
write_reg  in  1  write enable
read_reg  in  1  read enable
write_data  in  DATA_WIDTH  write data
data_1  out  DATA_WIDTH  registered read data for rs
data_2  out  DATA_WIDTH  registered read data for rt
read_valid  out  1  one-cycle pulse, data_1/data_2 updated this cycle
ready  out  1  bank initialised; accepts reads/writes

Behaviour:
- Reset (reset==0 at rising edge):
  - state=CLEAR, clear counter=0.
  - data_1=0, data_2=0, read_valid=0, ready=0.
  - Reset asserted mid-CLEAR or mid-RUN restarts the clear from index 0.
- CLEAR state:
  - Each cycle writes 0 to register[counter], then counter+1.
  - At counter==NUM_REGS-1, after writing that last entry: state=RUN, ready=1 on the next cycle.
  - ready rises exactly NUM_REGS cycles after reset deasserts (32 with defaults).
  - write_reg/read_reg ignored; read_valid stays 0; data outputs hold 0.
- RUN state (ready=1): no exit except reset.
- Write:
  - Performed if write_reg==1 at a rising edge: register[rd] <= write_data.
  - Suppressed when ZERO_REG==1 and rd==0.
- Read:
  - If read_reg==1 at a rising edge: data_1 <= reg[rs], data_2 <= reg[rt], read_valid <= 1.
  - Read latency = 1 cycle.
  - Otherwise read_valid <= 0 and data_1/data_2 hold their last values.
  - With ZERO_REG==1, rs==0 or rt==0 returns 0 regardless of array content.
- Simultaneous read and write in one cycle: both are performed. There is no write priority over read.
  - Same address, and address is not a hardwired zero: result is set by the optional feature below (bypass → new data; no bypass → old data).
  - rs==rt: both outputs show the same value.
- Back-to-back reads every cycle: read_valid stays high, outputs update every cycle.
- All addresses are in range by construction (NUM_REGS = 2**ADDR_WIDTH); no wrap or overflow case.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
REGBANK_BYPASS_EN
- Defined: on a same-cycle read+write where rs (or rt) == rd and the write is not suppressed, the corresponding data output captures write_data (write-first).
- Not defined: the read returns the pre-write register contents (read-first); the new value is visible from the next read onward.
- ZERO_REG suppression takes precedence in both cases: register 0 always reads 0 when ZERO_REG==1.

Test Plan:
- Reset/clear:
  - Hold reset=0 for 3 cycles, release → ready==0 for exactly 32 cycles, then 1.
  - Reads of all 32 registers → 0.
  - read_valid==0 throughout CLEAR, even with read_reg=1.
- Basic write/read:
  - Write rd=5, 0xDEADBEEF; next cycle read rs=5, rt=0 → one cycle later data_1==0xDEADBEEF, data_2==0, read_valid pulse of 1 cycle.
- Zero register:
  - ZERO_REG=1: write rd=0, 0xFFFFFFFF, then read rs=0 → data_1==0.
  - ZERO_REG=0: same sequence → data_1==0xFFFFFFFF.
- Same-cycle read/write:
  - Reg 7 holds 0x11111111; write rd=7, 0x22222222 with read rs=7 in the same cycle.
  - REGBANK_BYPASS_EN defined → data_1==0x22222222.
  - Undefined → data_1==0x11111111; following read → 0x22222222.
- Mid-operation reset:
  - Write rd=3, 0xA5A5A5A5; assert reset during RUN, and again at clear index 10 → clear restarts at index 0.
  - After ready: reg 3 reads 0; writes issued during CLEAR have no effect.
- Parametrisation:
  - DATA_WIDTH=16, ADDR_WIDTH=3 → ready after 8 cycles.
  - Write rd=7, 0xBEEF; read rt=7 → data_2==0xBEEF.
  - Streaming reads on 8 consecutive cycles → read_valid high for all 8.

Source files
------------

// File: rtl/registers_bank_param_if.sv
// -----------------------------------------------------------------------------
// registers_bank_param_if
// Bus between decode/writeback (master) and the register bank (slave).
//   rs, rt      : read addresses for ports 1 and 2
//   rd          : write address
//   write_reg   : write enable
//   read_reg    : read enable
//   write_data  : write data
//   data_1/2    : registered read data for rs / rt
//   read_valid  : one-cycle pulse, data_1/data_2 updated this cycle
//   ready       : bank initialised, accepts reads/writes
// -----------------------------------------------------------------------------
interface registers_bank_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  write_reg;
    logic                  read_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] data_1;
    logic [DATA_WIDTH-1:0] data_2;
    logic                  read_valid;
    logic                  ready;

    modport master (
        output rs, rt, rd, write_reg, read_reg, write_data,
        input  data_1, data_2, read_valid, ready
    );

    modport slave (
        input  rs, rt, rd, write_reg, read_reg, write_data,
        output data_1, data_2, read_valid, ready
    );
endinterface

// File: rtl/registers_bank_param.sv
// -----------------------------------------------------------------------------
// registers_bank_param
// Parametrised general-purpose register bank: one synchronous write port and
// two registered read ports (rs -> data_1, rt -> data_2).
// After reset an internal sequencer zeroes one register per cycle; ready rises
// once every entry has been cleared (NUM_REGS cycles after reset release).
//
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : registers_bank_param_if.slave (addresses, enables, data, status)
//
// Parameters:
//   DATA_WIDTH : register / data port width
//   ADDR_WIDTH : address width, NUM_REGS = 2**ADDR_WIDTH
//   ZERO_REG   : 1 = register 0 hardwired to zero
//
// Optional feature macro: REGBANK_BYPASS_EN
//   defined   : same-cycle read of the register being written returns the
//               new write data (write-first)
//   undefined : such a read returns the old contents (read-first)
// -----------------------------------------------------------------------------
module registers_bank_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    registers_bank_param_if.slave   bus
);
    localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam bit                    HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_data_1;
    logic [DATA_WIDTH-1:0] r_data_2;
    logic                  r_read_valid;
    logic                  r_ready;

    logic                  w_user_wr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_data_1;
    logic [DATA_WIDTH-1:0] w_rd_data_2;

    // User write qualification: only in RUN, never to a hardwired zero register.
    always_comb begin
        w_user_wr = 1'b0;
        if ((r_state == ST_RUN) && bus.write_reg && !(HAS_ZERO && (bus.rd == '0))) begin
            w_user_wr = 1'b1;
        end else begin
            w_user_wr = 1'b0;
        end
    end

    // Single array write port, shared by the clear sequencer and user writes.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (!reset) begin
            w_wr_en   = 1'b0;
            w_wr_addr = '0;
            w_wr_data = '0;
        end else if (r_state == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_cnt;
            w_wr_data = '0;
        end else begin
            w_wr_en   = w_user_wr;
            w_wr_addr = bus.rd;
            w_wr_data = bus.write_data;
        end
    end

    // Read port 1 mux: zero register first, then optional bypass, then array.
    always_comb begin
        w_rd_data_1 = '0;
        if (HAS_ZERO && (bus.rs == '0)) begin
            w_rd_data_1 = '0;
        end
`ifdef REGBANK_BYPASS_EN
        else if (w_user_wr && (bus.rd == bus.rs)) begin
            w_rd_data_1 = bus.write_data;
        end
`endif
        else begin
            w_rd_data_1 = r_regs[bus.rs];
        end
    end

    // Read port 2 mux: same priority as port 1.
    always_comb begin
        w_rd_data_2 = '0;
        if (HAS_ZERO && (bus.rt == '0)) begin
            w_rd_data_2 = '0;
        end
`ifdef REGBANK_BYPASS_EN
        else if (w_user_wr && (bus.rd == bus.rt)) begin
            w_rd_data_2 = bus.write_data;
        end
`endif
        else begin
            w_rd_data_2 = r_regs[bus.rt];
        end
    end

    // Register array storage; contents are zeroed by the sequencer, not by reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // Control FSM: clear sequencer, ready flag and registered read outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_data_1     <= '0;
            r_data_2     <= '0;
            r_read_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_read_valid <= 1'b0;
                    r_clr_cnt    <= r_clr_cnt + 1'b1;
                    // Last entry is written this cycle, so the bank is usable next.
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                    if (bus.read_reg) begin
                        r_data_1     <= w_rd_data_1;
                        r_data_2     <= w_rd_data_2;
                        r_read_valid <= 1'b1;
                    end else begin
                        r_read_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_CLEAR;
                    r_clr_cnt    <= '0;
                    r_read_valid <= 1'b0;
                    r_ready      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_1     = r_data_1;
    assign bus.data_2     = r_data_2;
    assign bus.read_valid = r_read_valid;
    assign bus.ready      = r_ready;

endmodule

// File: tb/tb_registers_bank_param.sv
// -----------------------------------------------------------------------------
// tb_registers_bank_param
// Scoreboard bench for registers_bank_param. Three instances share clock and
// reset: the default bank (dut_a, fully modelled), a ZERO_REG=0 bank (dut_z)
// and a DATA_WIDTH=16/ADDR_WIDTH=3 bank (dut_s).
// -----------------------------------------------------------------------------
module tb_registers_bank_param;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic clock;
    logic reset;

    registers_bank_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_a ();
    registers_bank_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_z ();
    registers_bank_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus_s ();

    registers_bank_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_a (
        .clock (clock), .reset (reset), .bus (bus_a.slave));
    registers_bank_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_z (
        .clock (clock), .reset (reset), .bus (bus_z.slave));
    registers_bank_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) dut_s (
        .clock (clock), .reset (reset), .bus (bus_s.slave));

    int          n_checks;
    int          n_errors;
    logic [31:0] m_regs [32];
    int          m_clear_left;
    int          m_since;
    bit          m_ready;
    logic [31:0] last_d1;
    logic [31:0] last_d2;
    exp_t        sb_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit wen,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef REGBANK_BYPASS_EN
        if (wen && (wa == a)) return wd;
`endif
        return m_regs[a];
    endfunction

    // One clock of stimulus on dut_a; model and scoreboard update, then outputs checked.
    task automatic cyc(input bit rst_n, input bit rden, input logic [4:0] a1, input logic [4:0] a2,
                       input bit wen, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        bit   exp_rv;
        @(negedge clock);
        reset            = rst_n;
        bus_a.read_reg   = rden;
        bus_a.rs         = a1;
        bus_a.rt         = a2;
        bus_a.write_reg  = wen;
        bus_a.rd         = wa;
        bus_a.write_data = wd;
        exp_rv = 1'b0;
        if (!rst_n) begin
            m_clear_left = 32;
            m_since      = 0;
            m_ready      = 1'b0;
            last_d1      = 32'd0;
            last_d2      = 32'd0;
            foreach (m_regs[i]) m_regs[i] = 32'd0;
        end else begin
            m_since++;
            if (m_clear_left > 0) begin
                m_clear_left--;
                if (m_clear_left == 0) m_ready = 1'b1;
            end else begin
                if (rden) begin
                    e.d1 = model_rd(a1, wen, wa, wd);
                    e.d2 = model_rd(a2, wen, wa, wd);
                    sb_q.push_back(e);
                    exp_rv = 1'b1;
                end
                if (wen && (wa != 5'd0)) m_regs[wa] = wd;
            end
        end
        @(posedge clock);
        #1;
        check_val("a_ready", 32'(bus_a.ready), 32'(m_ready));
        check_val("a_read_valid", 32'(bus_a.read_valid), 32'(exp_rv));
        check_val("z_ready", 32'(bus_z.ready), 32'(m_since >= 32));
        check_val("s_ready", 32'(bus_s.ready), 32'(m_since >= 8));
        if (bus_a.read_valid) begin
            if (sb_q.size() == 0) begin
                check_val("a_sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("a_data_1", bus_a.data_1, e.d1);
                check_val("a_data_2", bus_a.data_2, e.d2);
                last_d1 = e.d1;
                last_d2 = e.d2;
            end
        end else begin
            check_val("a_hold_1", bus_a.data_1, last_d1);
            check_val("a_hold_2", bus_a.data_2, last_d2);
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_clear_left = 32;
        m_since = 0;
        m_ready = 1'b0;
        last_d1 = 32'd0;
        last_d2 = 32'd0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        reset = 1'b0;
        bus_a.read_reg = 1'b0; bus_a.write_reg = 1'b0; bus_a.rs = 5'd0; bus_a.rt = 5'd0;
        bus_a.rd = 5'd0; bus_a.write_data = 32'd0;
        bus_z.read_reg = 1'b0; bus_z.write_reg = 1'b0; bus_z.rs = 5'd0; bus_z.rt = 5'd0;
        bus_z.rd = 5'd0; bus_z.write_data = 32'd0;
        bus_s.read_reg = 1'b0; bus_s.write_reg = 1'b0; bus_s.rs = 3'd0; bus_s.rt = 3'd0;
        bus_s.rd = 3'd0; bus_s.write_data = 16'd0;

        // Reset held for 3 cycles, then CLEAR with reads/writes that must be ignored.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 1'b1, 5'(i), 5'(31 - i), 1'b1, 5'(i), 32'hCAFE_0000 + 32'(i));

        // Every register reads zero after the clear.
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0);

        // Basic write then read, followed by an idle cycle (pulse must drop).
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0);
        idle();

        // Hardwired zero register.
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0);

        // Same-cycle read/write of register 7, then a follow-up read.
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1111_1111);
        cyc(1'b1, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h2222_2222);
        cyc(1'b1, 1'b1, 5'd7, 5'd5, 1'b0, 5'd0, 32'd0);

        // ZERO_REG=0 instance: register 0 is ordinary.
        bus_z.write_reg = 1'b1; bus_z.rd = 5'd0; bus_z.write_data = 32'hFFFF_FFFF;
        idle();
        bus_z.write_reg = 1'b0; bus_z.read_reg = 1'b1; bus_z.rs = 5'd0; bus_z.rt = 5'd0;
        idle();
        check_val("z_read_valid", 32'(bus_z.read_valid), 32'd1);
        check_val("z_data_1_reg0", bus_z.data_1, 32'hFFFF_FFFF);
        bus_z.read_reg = 1'b0;
        idle();
        check_val("z_read_valid_drop", 32'(bus_z.read_valid), 32'd0);

        // Small instance: write/read then 8 streaming reads.
        bus_s.write_reg = 1'b1; bus_s.rd = 3'd7; bus_s.write_data = 16'hBEEF;
        idle();
        bus_s.write_reg = 1'b0; bus_s.read_reg = 1'b1; bus_s.rs = 3'd0; bus_s.rt = 3'd7;
        idle();
        check_val("s_data_2", 32'(bus_s.data_2), 32'h0000_BEEF);
        check_val("s_data_1_zero", 32'(bus_s.data_1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_s.rs = 3'(i);
            idle();
            check_val("s_stream_valid", 32'(bus_s.read_valid), 32'd1);
            check_val("s_stream_data_2", 32'(bus_s.data_2), 32'h0000_BEEF);
        end
        bus_s.read_reg = 1'b0;
        idle();
        check_val("s_stream_end", 32'(bus_s.read_valid), 32'd0);

        // Random back-to-back traffic on the main bank.
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom());

        // Reset mid-RUN, again at clear index 10, then a full clear with ignored writes.
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA5A5_A5A5);
        cyc(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 32'h1234_0000 + 32'(i));
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 5'd3, 5'd9, 1'b1, 5'd3, 32'h5A5A_0000 + 32'(i));
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 5'(i), 5'd3, 1'b0, 5'd0, 32'd0);
        idle();

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
